// File: rtl/qrisc32_if_prefetch.sv
// qrisc32_if_prefetch: Qrisc32 instruction-fetch stage with a word-addressed prefetch FIFO feeding ID.
// Optional macro IF_BYPASS_EN: words fetched while the FIFO is empty go straight to ID (one cycle sooner).
module qrisc32_if_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rdata,
  input  logic                       pipe_stall,
  input  logic                       jmp_taken,
  input  logic [31:0]                jmp_addr,
  output logic [31:0]                instruction,
  output logic [31:0]                pc,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W    = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head_entry;
  logic [PTR_W-1:0]  head_ptr;
  logic [PTR_W-1:0]  tail_ptr;
  logic [LVL_W-1:0]  level;
  logic [31:0]       fetch_pc;
  logic              fifo_empty;
  logic              xfer;
  logic              bypass;
  logic              push;
  logic              pop;

  // Requests are withheld while full, during reset and in a redirect cycle,
  // so an ack in any of those cycles is simply not a transfer.
  always_comb begin
    fifo_empty = (level == '0);
    imem_req   = !reset && (level < FULL_LVL) && !jmp_taken;
    xfer       = imem_req && imem_ack;
`ifdef IF_BYPASS_EN
    bypass     = xfer && fifo_empty && !pipe_stall;
`else
    bypass     = 1'b0;
`endif
    push       = xfer && !bypass;
    pop        = !reset && !jmp_taken && !pipe_stall && !fifo_empty;
    head_entry = mem[head_ptr];
  end

  // NOTE: FIFO storage has no reset; level and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= {fetch_pc, imem_rdata};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr    <= '0;
      tail_ptr    <= '0;
      level       <= '0;
      fetch_pc    <= RESET_PC;
      instruction <= '0;
      pc          <= RESET_PC;
    end else if (jmp_taken) begin
      head_ptr    <= '0;
      tail_ptr    <= '0;
      level       <= '0;
      fetch_pc    <= jmp_addr;
      instruction <= '0;
      pc          <= jmp_addr;
    end else begin
      if (xfer) fetch_pc <= fetch_pc + 32'd1;
      if (push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop)  head_ptr <= head_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: ;
      endcase
      if (!pipe_stall) begin
        if (pop) begin
          instruction <= head_entry.instr;
          pc          <= head_entry.pc;
        end else if (bypass) begin
          instruction <= imem_rdata;
          pc          <= fetch_pc;
        end else begin
          instruction <= '0;
        end
      end
    end
  end

  assign imem_addr  = fetch_pc;
  assign fifo_level = level;

endmodule

// File: tb/tb_qrisc32_if_prefetch.sv
// Self-checking bench for qrisc32_if_prefetch: directed scenarios plus a random phase against a queue model.
// Honours IF_BYPASS_EN so the same bench covers both builds.
module tb_qrisc32_if_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef IF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        pipe_stall;
  logic        jmp_taken;
  logic [31:0] jmp_addr;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [2:0]  fifo_level;

  always #5 clk = ~clk;

  qrisc32_if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pipe_stall(pipe_stall), .jmp_taken(jmp_taken), .jmp_addr(jmp_addr),
    .instruction(instruction), .pc(pc), .fifo_level(fifo_level)
  );

  // Reference model: a queue of fetched {pc, word} pairs plus the ID-facing registers.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } word_t;
  word_t       q[$];
  logic [31:0] m_fpc;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  bit          rnd_data = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic exp_req();
    return !reset && (q.size() < DEPTH) && !jmp_taken;
  endfunction

  // One clock cycle: drive inputs, check all outputs, advance the model at the edge.
  task automatic step(input logic rst, input logic ack, input logic stall,
                      input logic jmp, input logic [31:0] jaddr);
    logic [31:0] rdata;
    logic        r, xfer, byp;
    word_t       w;
    rdata      = rnd_data ? $urandom : m_fpc + 32'h100;
    reset      = rst;
    imem_ack   = ack;
    pipe_stall = stall;
    jmp_taken  = jmp;
    jmp_addr   = jaddr;
    imem_rdata = rdata;
    #1;
    r = exp_req();
    check("imem_req", 32'(imem_req), 32'(r));
    if (r) check("imem_addr", imem_addr, m_fpc);
    check("instruction", instruction, m_instr);
    check("pc", pc, m_pc);
    check("fifo_level", 32'(fifo_level), 32'(q.size()));
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_fpc = RESET_PC; m_instr = '0; m_pc = RESET_PC;
    end else if (jmp) begin
      q.delete();
      m_fpc = jaddr; m_instr = '0; m_pc = jaddr;
    end else begin
      xfer = r && ack;
      byp  = BYP && xfer && (q.size() == 0) && !stall;
      if (!stall) begin
        if (q.size() != 0) begin
          w = q.pop_front();
          m_instr = w.instr; m_pc = w.pc;
        end else if (byp) begin
          m_instr = rdata; m_pc = m_fpc;
        end else begin
          m_instr = '0;
        end
      end
      if (xfer && !byp) q.push_back('{pc: m_fpc, instr: rdata});
      if (xfer) m_fpc = m_fpc + 32'd1;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    pipe_stall = 1'b0; jmp_taken = 1'b0; jmp_addr = '0;
    m_fpc = RESET_PC; m_instr = '0; m_pc = RESET_PC;
    @(posedge clk); #1;

    // Reset state, then continuous ack with rdata = addr + 0x100.
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    if (!BYP) step(0, 1, 0, 0, 0);
    check("first_instr", instruction, 32'h100);
    check("first_pc", pc, 32'h0);
    step(0, 1, 0, 0, 0);
    check("second_instr", instruction, 32'h101);
    repeat (6) step(0, 1, 0, 0, 0);

    // Stall for 8 cycles: outputs frozen, FIFO fills and stops requesting.
    repeat (8) step(0, 1, 1, 0, 0);
    check("stall_full_level", 32'(fifo_level), 32'(DEPTH));
    check("stall_full_req", 32'(imem_req), 32'h0);
    repeat (8) step(0, 1, 0, 0, 0);

    // Redirect with three entries buffered.
    for (int i = 0; i < 8 && q.size() != 3; i++) step(0, 1, 1, 0, 0);
    check("pre_jump_level", 32'(fifo_level), 32'd3);
    step(0, 1, 0, 1, 32'h40);
    check("jump_level", 32'(fifo_level), 32'h0);
    check("jump_instr", instruction, 32'h0);
    check("jump_addr", imem_addr, 32'h40);
    repeat (4) step(0, 1, 0, 0, 0);

    // Redirect together with stall and ack: redirect wins.
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 32'h80);
    check("jump_stall_pc", pc, 32'h80);
    repeat (3) step(0, 1, 1, 0, 0);
    repeat (6) step(0, 1, 0, 0, 0);

    // Sparse acks produce NOP bubbles.
    step(0, 1, 0, 1, 32'h0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    check("bubble_instr", instruction, 32'h0);
    check("bubble_pc", pc, 32'h1);

    // Address wrap, then reset mid-stream (also beating a jump).
    step(0, 1, 0, 1, 32'hFFFF_FFFF);
    repeat (5) step(0, 1, 0, 0, 0);
    step(1, 1, 0, 1, 32'h55);
    check("rst_instr", instruction, 32'h0);
    check("rst_pc", pc, RESET_PC);
    check("rst_level", 32'(fifo_level), 32'h0);
    repeat (4) step(0, 1, 0, 0, 0);

    // Random phase.
    rnd_data = 1'b1;
    repeat (400) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
